// File: rtl/fss_seg_pkg.sv
// Shared types, glyph constants and FSM encoding for the 7-segment display controller.
// Segment bit order is {g,f,e,d,c,b,a}, active-high inside the design.
package fss_seg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h40;

    typedef enum logic [1:0] {
        IDLE,
        HEX,
        CONV,
        UPDATE
    } seg_state_t;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        unique case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fss_bin_to_bcd.sv
// Iterative double-dabble: one input bit per cycle for P_DATA_WIDTH cycles after start.
// overflow latches any 1 bit shifted out of the top BCD nibble.
module fss_bin_to_bcd
    import fss_seg_pkg::*;
#(
    parameter int P_DATA_WIDTH = 16,
    parameter int P_NUM_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [P_DATA_WIDTH-1:0]   din,
    output logic                      done,
    output logic [4*P_NUM_DIGITS-1:0] bcd,
    output logic                      overflow
);

    localparam int BW = 4 * P_NUM_DIGITS;
    localparam int CW = $clog2(P_DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(P_DATA_WIDTH - 1);

    logic [P_DATA_WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]           bcd_q, bcd_d;
    logic [BW-1:0]           adj;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    always_comb begin
        adj = bcd_q;
        for (int unsigned i = 0; i < P_NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        ovf_d  = ovf_q;
        done_d = 1'b0;
        if (start) begin
            bin_d  = din;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
            ovf_d  = 1'b0;
        end else if (busy_q) begin
            // Adjusted top bit leaving the register means the value needs another digit
            bcd_d = {adj[BW-2:0], bin_q[P_DATA_WIDTH-1]};
            bin_d = {bin_q[P_DATA_WIDTH-2:0], 1'b0};
            ovf_d = ovf_q | adj[BW-1];
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/fss_seg_display_ctrl.sv
// Valid/ready 7-segment controller: hex or decimal rendering, leading-zero blanking, overflow dash.
// Optional FSS_SEG_DISPLAY_NEG_EN: decimal input is two's complement and gets a minus sign.
module fss_seg_display_ctrl
    import fss_seg_pkg::*;
#(
    parameter int P_NUM_DIGITS = 4,
    parameter int P_DATA_WIDTH = 16,
    parameter int P_ACTIVE_LOW = 1
) (
    input  logic                         I_CLK,
    input  logic                         I_NRESET,
    input  logic                         I_VALID,
    output logic                         O_READY,
    input  logic [P_DATA_WIDTH-1:0]      I_DATA,
    input  logic                         I_MODE,
    input  logic                         I_BLANK_LEADING,
    output logic [P_NUM_DIGITS-1:0][6:0] O_7_SEGMENT_DISPLAY,
    output logic                         O_OVERFLOW
);

    localparam int ND = P_NUM_DIGITS;
    localparam int W  = P_DATA_WIDTH;
    localparam int BW = 4 * ND;
    localparam int XW = (W > BW) ? W : BW;

    seg_state_t state_q, state_d;

    logic [W-1:0]         data_q, data_d;
    logic                 blank_q, blank_d;
    logic [BW-1:0]        res_q, res_d;
    logic                 res_ovf_q, res_ovf_d;
    logic [ND-1:0][6:0]   seg_q, seg_d;
    logic                 ovf_q, ovf_d;

    logic                 take, conv_start, load_hex, load_conv, do_update;
    logic [W-1:0]         conv_din;
    logic                 conv_done, conv_ovf;
    logic [BW-1:0]        conv_bcd;
    logic [XW-1:0]        data_x;
    logic                 hex_ovf;
    logic                 neg_ovf;
    int unsigned          msd;
    logic [ND-1:0][6:0]   disp;

`ifdef FSS_SEG_DISPLAY_NEG_EN
    logic neg_q, neg_d;

    assign conv_din = I_DATA[W-1] ? (-I_DATA) : I_DATA;
    // Signed results lose the top digit to the minus sign
    assign neg_ovf  = neg_q && (conv_bcd[BW-1 -: 4] != 4'h0);
`else
    assign conv_din = I_DATA;
    assign neg_ovf  = 1'b0;
`endif

    fss_bin_to_bcd #(
        .P_DATA_WIDTH (W),
        .P_NUM_DIGITS (ND)
    ) u_bin_to_bcd (
        .clk      (I_CLK),
        .rst_n    (I_NRESET),
        .start    (conv_start),
        .din      (conv_din),
        .done     (conv_done),
        .bcd      (conv_bcd),
        .overflow (conv_ovf)
    );

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (I_VALID) state_d = I_MODE ? CONV : HEX;
            HEX:     state_d = UPDATE;
            CONV:    if (conv_done) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        O_READY    = (state_q == IDLE);
        take       = I_VALID && (state_q == IDLE);
        conv_start = take && I_MODE;
        load_hex   = (state_q == HEX);
        load_conv  = (state_q == CONV) && conv_done;
        do_update  = (state_q == UPDATE);
    end

    always_comb begin
        data_x  = XW'(data_q);
        hex_ovf = (data_x >> BW) != '0;
    end

    always_comb begin
        data_d    = data_q;
        blank_d   = blank_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
`ifdef FSS_SEG_DISPLAY_NEG_EN
        neg_d     = neg_q;
`endif
        if (take) begin
            data_d  = I_DATA;
            blank_d = I_BLANK_LEADING;
`ifdef FSS_SEG_DISPLAY_NEG_EN
            neg_d   = I_MODE && I_DATA[W-1];
`endif
        end
        if (load_hex) begin
            res_d     = BW'(data_x);
            res_ovf_d = hex_ovf;
        end else if (load_conv) begin
            res_d     = conv_bcd;
            res_ovf_d = conv_ovf || neg_ovf;
        end
    end

    // Digit images are built from the result register and only committed in UPDATE
    always_comb begin
        msd = 0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (res_q[4*i +: 4] != 4'h0) msd = i;
        end
        disp = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            if (res_ovf_q) begin
                disp[i] = SEG_DASH;
            end else if (blank_q && (i > msd)) begin
                disp[i] = SEG_BLANK;
            end else begin
                disp[i] = hex_to_seg(res_q[4*i +: 4]);
            end
`ifdef FSS_SEG_DISPLAY_NEG_EN
            if (neg_q && !res_ovf_q && (i == (blank_q ? msd + 1 : ND - 1))) begin
                disp[i] = SEG_DASH;
            end
`endif
        end
        seg_d = do_update ? disp : seg_q;
        ovf_d = do_update ? res_ovf_q : ovf_q;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            data_q    <= '0;
            blank_q   <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
            seg_q     <= {ND{SEG_BLANK}};
            ovf_q     <= 1'b0;
`ifdef FSS_SEG_DISPLAY_NEG_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            data_q    <= data_d;
            blank_q   <= blank_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
`ifdef FSS_SEG_DISPLAY_NEG_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign O_7_SEGMENT_DISPLAY = (P_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign O_OVERFLOW          = ovf_q;

endmodule

// File: doc/fss_seg_display_ctrl.md
Name: fss_seg_display_ctrl

Overview:
Parametrised 7-segment display controller, successor to the fixed 4-digit display path driven by fss_top.
- Accepts a binary value through a valid/ready handshake.
- Renders it in hex, or in decimal via an iterative double-dabble conversion, across P_NUM_DIGITS digits.
- Supports leading-zero blanking and overflow indication.
- Sits between fss_top's datapath and the board's O_7_SEGMENT_DISPLAY pins.

Parameters:
P_NUM_DIGITS, 4, number of 7-segment digits driven (1..8)
P_DATA_WIDTH, 16, width of binary input value (4..32)
P_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (DE-series boards); 0 = active-high

Ports:
I_CLK  input  1  system clock (50 MHz)
I_NRESET  input  1  asynchronous active-low reset
I_VALID  input  1  new value present on I_DATA/I_MODE/I_BLANK_LEADING
O_READY  output  1  controller idle, accepts a value
I_DATA  input  P_DATA_WIDTH  binary value to display
I_MODE  input  1  0 = hex, 1 = decimal
I_BLANK_LEADING  input  1  1 = blank leading zero digits
O_7_SEGMENT_DISPLAY  output  [6:0] x [P_NUM_DIGITS-1:0]  per-digit segments, bit order {g,f,e,d,c,b,a}; index 0 = least significant digit
O_OVERFLOW  output  1  value not representable in P_NUM_DIGITS digits

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is asynchronous and active-low on I_NRESET.
- Reset values: O_READY=1, O_OVERFLOW=0, all digits blank (all segments off, polarity per P_ACTIVE_LOW), FSM=IDLE.
- Handshake:
  - Transfer occurs on a rising edge with I_VALID && O_READY. I_DATA, I_MODE and I_BLANK_LEADING are latched at that edge.
  - O_READY drops the next cycle and returns to 1 in the cycle after UPDATE.
  - I_VALID while O_READY=0 is ignored; no queuing.
- FSM: IDLE -> (transfer) -> hex ? HEX : CONV -> UPDATE -> IDLE.
  - HEX: one cycle; nibble i of latched data forms digit i.
  - CONV: exactly P_DATA_WIDTH cycles of double-dabble on a 4*P_NUM_DIGITS-bit BCD register.
  - UPDATE: one cycle; outputs are registered from the result.
- Latency (transfer edge to new display value): hex = 2 cycles; decimal = P_DATA_WIDTH+2 cycles.
- Display atomicity: the display and O_OVERFLOW hold their previous values throughout conversion and change only at UPDATE, all digits together.
- Overflow:
  - Decimal: overflow is set if any 1 bit shifts out of the top BCD nibble during CONV, which is equivalent to value >= 10^P_NUM_DIGITS.
  - Hex: overflow is set if P_DATA_WIDTH > 4*P_NUM_DIGITS and any upper bit is 1.
  - On overflow every digit shows dash (g only) and O_OVERFLOW=1.
  - Otherwise O_OVERFLOW=0 at UPDATE.
- Blanking:
  - With I_BLANK_LEADING=1, digits above the most significant nonzero digit are blank.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanking is not applied when overflowed.
- Hex glyphs: 0-9, A, b, C, d, E, F.
- Polarity: all output encodings are inverted when P_ACTIVE_LOW=1.
- Reset mid-conversion: aborts immediately, restores reset values, and the conversion result is discarded.

Optional Feature:
FSS_SEG_DISPLAY_NEG_EN
- Defined: in decimal mode I_DATA is two's complement.
  - Negative values are converted as magnitude and a minus sign (dash) is placed in the digit just above the most significant digit (with blanking), or in the top digit otherwise.
  - Overflow if the magnitude needs more than P_NUM_DIGITS-1 digits.
  - Hex mode is unaffected.
- Undefined: I_DATA is always unsigned; no sign logic is synthesised.

Decomposition:
- Package fss_seg_pkg contains:
  - typedef seg_t (logic [6:0])
  - constants SEG_BLANK and SEG_DASH (active-high)
  - function hex_to_seg
  - enum seg_state_t {IDLE, HEX, CONV, UPDATE}
- Sub-module fss_bin_to_bcd: iterative double-dabble with start/done, overflow flag, and parameters P_DATA_WIDTH and P_NUM_DIGITS.

Test Plan:
All tests use defaults (4 digits, 16-bit, active-low).
- Reset, then release -> O_READY=1, O_OVERFLOW=0, all digits 7'h7F.
- Hex 16'hBEEF, blank=0 -> 2 cycles after transfer digits[3:0] = 7'h03, 7'h06, 7'h06, 7'h0E; O_READY high again the following cycle.
- Decimal 16'd1234 -> 18 cycles after transfer digits = 7'h79, 7'h24, 7'h30, 7'h19; I_VALID pulsed at cycle 5 with 16'd9999 is ignored and the display stays 1234.
- Decimal 16'd10000 -> all digits 7'h3F, O_OVERFLOW=1. Follow with decimal 16'd7, blank=1 -> digits 7'h7F, 7'h7F, 7'h7F, 7'h78, O_OVERFLOW=0.
- Decimal 16'd0, blank=1 -> digit0 = 7'h40, others 7'h7F.
- Assert I_NRESET low at CONV cycle 8 of 16'd4321 -> display immediately 7'h7F on all digits; after release O_READY=1 and 4321 never appears.
